// File: rtl/enc_input_filter.sv
// rtl/enc_input_filter.sv - synchroniser, debouncer and push-switch event FSM for a rotary encoder
// Optional long-press support is enabled with `define ENC_FILTER_SW_LONG_EN.

module enc_filter_deb #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic accept
);
  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;

  assign accept = (din != level) && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt_q <= '0;
    end else if (din == level) begin
      cnt_q <= '0;
    end else if (accept) begin
      level <= din;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

module enc_input_filter #(
  parameter int DEB_CYCLES    = 5000,
  parameter int SW_DEB_CYCLES = 500000,
  parameter int LONG_CYCLES   = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_sw,
  output logic a_clean,
  output logic b_clean,
  output logic sw_level,
  output logic sw_press,
  output logic sw_release,
  output logic sw_long
);
  generate
    if (DEB_CYCLES < 2 || SW_DEB_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_param
      $error("enc_input_filter: cycle parameters must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG} sw_state_t;

  logic [2:0] sync1_q, sync2_q;
  logic       sw_lvl_raw, sw_acc, a_acc, b_acc;
  logic       sw_rise, sw_fall;
  sw_state_t  state_q, state_d;
  logic       press_d, release_d, long_d;

  // Pins idle high through their pull-ups, so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= {raw_sw, raw_b, raw_a};
      sync2_q <= sync1_q;
    end
  end

  enc_filter_deb #(.LIMIT(DEB_CYCLES)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[0]), .level(a_clean), .accept(a_acc)
  );

  enc_filter_deb #(.LIMIT(DEB_CYCLES)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[1]), .level(b_clean), .accept(b_acc)
  );

  enc_filter_deb #(.LIMIT(SW_DEB_CYCLES)) u_deb_sw (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[2]), .level(sw_lvl_raw), .accept(sw_acc)
  );

  assign sw_level = ~sw_lvl_raw;

  // Events are decoded from the accept strobe so the pulses land on the same edge as sw_level.
  assign sw_rise = sw_acc & ~sync2_q[2];
  assign sw_fall = sw_acc &  sync2_q[2];

`ifdef ENC_FILTER_SW_LONG_EN
  localparam int HW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  logic [HW-1:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sw_press   <= 1'b0;
      sw_release <= 1'b0;
      sw_long    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_press   <= press_d;
      sw_release <= release_d;
      sw_long    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef ENC_FILTER_SW_LONG_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sw_rise) begin
          press_d = 1'b1;
          state_d = S_PRESSED;
`ifdef ENC_FILTER_SW_LONG_EN
          hold_d  = '0;
`endif
        end
      end
      S_PRESSED: begin
        // Release is checked first so it wins over a coincident long-press expiry.
        if (sw_fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
        end
`ifdef ENC_FILTER_SW_LONG_EN
        else if (hold_q == HW'(LONG_CYCLES - 1)) begin
          long_d  = 1'b1;
          state_d = S_LONG;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
`ifdef ENC_FILTER_SW_LONG_EN
      S_LONG: begin
        if (sw_fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_enc_input_filter.sv
// tb/tb_enc_input_filter.sv - directed self-checking bench for enc_input_filter
module tb_enc_input_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_a = 1'b1, raw_b = 1'b1, raw_sw = 1'b1;
  logic a_clean, b_clean, sw_level, sw_press, sw_release, sw_long;

  int checks = 0;
  int errors = 0;
  int n_press = 0, n_release = 0, n_long = 0;
  int s_press, s_release, s_long;
  logic seen_low;

`ifdef ENC_FILTER_SW_LONG_EN
  localparam logic LONG_EXP = 1'b1;
`else
  localparam logic LONG_EXP = 1'b0;
`endif

  enc_input_filter #(
    .DEB_CYCLES(4), .SW_DEB_CYCLES(8), .LONG_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_a(raw_a), .raw_b(raw_b), .raw_sw(raw_sw),
    .a_clean(a_clean), .b_clean(b_clean), .sw_level(sw_level),
    .sw_press(sw_press), .sw_release(sw_release), .sw_long(sw_long)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sw_press)   n_press++;
    if (sw_release) n_release++;
    if (sw_long)    n_long++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_press = n_press;
    s_release = n_release;
    s_long = n_long;
  endtask

  logic [1:0] quad_seq [4];

  initial begin
    quad_seq[0] = 2'b01; quad_seq[1] = 2'b00; quad_seq[2] = 2'b10; quad_seq[3] = 2'b11;

    // Reset with random pin levels
    for (int i = 0; i < 6; i++) begin
      raw_a = 1'($urandom); raw_b = 1'($urandom); raw_sw = 1'($urandom);
      tick();
    end
    check("rst_a", a_clean, 1);
    check("rst_b", b_clean, 1);
    check("rst_level", sw_level, 0);
    check("rst_pulses", {sw_press, sw_release, sw_long}, 0);
    raw_a = 1'b1; raw_b = 1'b1; raw_sw = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // A/B latency: change visible after the 6th edge
    raw_a = 1'b0;
    repeat (5) tick();
    check("a_lat_hold", a_clean, 1);
    tick();
    check("a_lat_fall", a_clean, 0);
    check("b_stays", b_clean, 1);
    raw_a = 1'b1;
    repeat (5) tick();
    check("a_rise_hold", a_clean, 0);
    tick();
    check("a_rise", a_clean, 1);

    // Glitch of 3 cycles is discarded
    seen_low = 1'b0;
    raw_a = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen_low |= ~a_clean; end
    raw_a = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); seen_low |= ~a_clean; end
    check("glitch3", seen_low, 0);

    // 3 low / 1 high / 3 low: counter restarts, no acceptance
    seen_low = 1'b0;
    raw_a = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen_low |= ~a_clean; end
    raw_a = 1'b1;
    tick(); seen_low |= ~a_clean;
    raw_a = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen_low |= ~a_clean; end
    raw_a = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); seen_low |= ~a_clean; end
    check("glitch313", seen_low, 0);

    // Quadrature 11 -> 01 -> 00 -> 10 -> 11, 10 cycles per state
    begin
      logic [1:0] prev;
      logic [1:0] cur;
      prev = 2'b11;
      for (int i = 0; i < 4; i++) begin
        cur = quad_seq[i];
        raw_a = cur[1]; raw_b = cur[0];
        repeat (5) tick();
        check($sformatf("quad%0d_old", i), {a_clean, b_clean}, prev);
        tick();
        check($sformatf("quad%0d_new", i), {a_clean, b_clean}, cur);
        repeat (4) tick();
        prev = cur;
      end
    end

    // Short press: 15 cycles low
    snap();
    raw_sw = 1'b0;
    repeat (9) tick();
    check("sp_level_pre", sw_level, 0);
    tick();
    check("sp_level", sw_level, 1);
    check("sp_press", sw_press, 1);
    tick();
    check("sp_press_1cyc", sw_press, 0);
    repeat (4) tick();
    raw_sw = 1'b1;
    repeat (9) tick();
    check("sp_level_hold", sw_level, 1);
    check("sp_rel_pre", sw_release, 0);
    tick();
    check("sp_level_off", sw_level, 0);
    check("sp_release", sw_release, 1);
    tick();
    check("sp_release_1cyc", sw_release, 0);
    check("sp_npress", n_press - s_press, 1);
    check("sp_nrelease", n_release - s_release, 1);
    check("sp_nolong", n_long - s_long, 0);
    repeat (4) tick();

    // Long press: 40 cycles low, long pulse 20 cycles after press
    snap();
    raw_sw = 1'b0;
    repeat (10) tick();
    check("lp_press", sw_press, 1);
    repeat (19) tick();
    check("lp_long_pre", sw_long, 0);
    tick();
    check("lp_long", sw_long, LONG_EXP);
    tick();
    check("lp_long_1cyc", sw_long, 0);
    repeat (9) tick();
    raw_sw = 1'b1;
    repeat (9) tick();
    check("lp_level_hold", sw_level, 1);
    tick();
    check("lp_release", sw_release, 1);
    tick();
    check("lp_nlong", n_long - s_long, LONG_EXP);
    check("lp_npress", n_press - s_press, 1);
    repeat (4) tick();

    // Reset during PRESSED, switch still held through deassertion
    raw_sw = 1'b0;
    repeat (10) tick();
    check("ra_press", sw_press, 1);
    repeat (5) tick();
    snap();
    rst_n = 1'b0;
    #1;
    check("ra_level", sw_level, 0);
    check("ra_pulses", {sw_press, sw_release, sw_long}, 0);
    check("ra_ab", {a_clean, b_clean}, 2'b11);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (9) tick();
    check("ra_no_pulse", (n_press - s_press) + (n_release - s_release) + (n_long - s_long), 0);
    check("ra_level_pre", sw_level, 0);
    tick();
    check("ra_fresh_press", sw_press, 1);
    check("ra_fresh_level", sw_level, 1);
    raw_sw = 1'b1;
    repeat (12) tick();
    check("ra_final_level", sw_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
